// File: rtl/aip_conv1d_core.sv
// AIP 1-D processing core: streams L samples from MemIn0 through pass / moving-sum / difference,
// arithmetic-shifts each result and writes it to MemOut0. Define AIP_CONV1D_SAT_EN for saturation.
module aip_conv1d_core #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH_MEMI = 6,
  parameter int ADDR_WIDTH_MEMO = 6,
  parameter int TAPS            = 4,
  parameter int STATUS_WIDTH    = 8,
  parameter int INT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst_a,
  input  logic                       en_s,
  input  logic                       start_IPcore,
  input  logic [DATA_WIDTH-1:0]      data_MemIn0,
  output logic [ADDR_WIDTH_MEMI-1:0] rd_addr_MemIn0,
  input  logic [DATA_WIDTH-1:0]      data_ConfigReg,
  output logic [DATA_WIDTH-1:0]      data_MemOut0,
  output logic [ADDR_WIDTH_MEMO-1:0] wr_addr_MemOut0,
  output logic                       wr_en_MemOut0,
  output logic [STATUS_WIDTH-1:0]    status_IPcore,
  output logic [INT_WIDTH-1:0]       int_IPcore
);
  localparam int EW   = DATA_WIDTH + $clog2(TAPS) + 1;
  localparam int LMAX = (ADDR_WIDTH_MEMI < ADDR_WIDTH_MEMO) ? (1 << ADDR_WIDTH_MEMI)
                                                            : (1 << ADDR_WIDTH_MEMO);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t                          state_q, state_d;
  logic [16:0]                     len_q, len_d;
  logic [1:0]                      mode_q, mode_d;
  logic [4:0]                      sh_q, sh_d;
  logic [ADDR_WIDTH_MEMI-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH_MEMO-1:0]      idx_q, idx_d, wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]           wr_data_q, wr_data_d, hold_q, hold_d;
  logic                            wr_en_q, wr_en_d, dvld_q, dvld_d, busy_q, busy_d;
  logic                            err_q, err_d, frz_q, frz_d, sat_flag;
  logic [1:0]                      int_q, int_d;
  // Only the TAPS-1 previous samples need storing; the newest comes straight off the bus.
  logic [TAPS-2:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [DATA_WIDTH-1:0]           x_in, y;
  logic signed [EW-1:0]            acc, shf;
  logic [15:0]                     cfg_len;
  logic                            unused_cfg;

  assign unused_cfg = ^data_ConfigReg[DATA_WIDTH-1:23];

  function automatic logic signed [EW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(EW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // The memory keeps following rd_addr while we are frozen, so the sample that was on the
  // bus when en_s dropped is held and replayed on resume.
  assign frz_d = ~en_s;
  assign hold_d = (!en_s && !frz_q) ? data_MemIn0 : hold_q;
  assign x_in  = frz_q ? hold_q : data_MemIn0;

  always_comb begin
    acc = sext(x_in);
    case (mode_q)
      2'b01:   for (int k = 0; k < TAPS-1; k++) acc = acc + sext(win_q[k]);
      2'b10:   acc = acc - sext(win_q[0]);
      default: ;
    endcase
    shf = acc >>> sh_q;
  end

`ifdef AIP_CONV1D_SAT_EN
  logic sat_q, sat_d, ovf;
  assign ovf = shf[EW-1:DATA_WIDTH-1] != {(EW-DATA_WIDTH+1){shf[EW-1]}};
  assign y = !ovf ? shf[DATA_WIDTH-1:0]
               : (shf[EW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}});
  assign sat_d = (state_q == S_IDLE && start_IPcore) ? 1'b0 : (sat_q | (dvld_q & ovf));
  assign sat_flag = sat_q;
  always_ff @(posedge clk) begin
    if (rst_a)     sat_q <= 1'b0;
    else if (en_s) sat_q <= sat_d;
  end
`else
  logic unused_hi;
  assign unused_hi = ^shf[EW-1:DATA_WIDTH];
  assign y = shf[DATA_WIDTH-1:0];
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    sh_d      = sh_q;
    rd_addr_d = rd_addr_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    int_d     = 2'b00;
    err_d     = err_q;
    win_d     = win_q;
    dvld_d    = (state_q == S_RUN);
    cfg_len   = data_ConfigReg[15:0];
    if (dvld_q) begin
      win_d[0] = x_in;
      for (int k = 1; k < TAPS-1; k++) win_d[k] = win_q[k-1];
      wr_en_d   = 1'b1;
      wr_data_d = y;
      wr_addr_d = idx_q;
      idx_d     = idx_q + 1'b1;
    end
    case (state_q)
      S_IDLE: if (start_IPcore) begin
        mode_d    = data_ConfigReg[17:16];
        sh_d      = data_ConfigReg[22:18];
        len_d     = ({1'b0, cfg_len} > 17'(LMAX)) ? 17'(LMAX) : {1'b0, cfg_len};
        err_d     = 1'b0;
        win_d     = '0;
        idx_d     = '0;
        rd_addr_d = '0;
        if (data_ConfigReg[17:16] == 2'b11) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (cfg_len == 16'd0) state_d = S_DONE;
        else                           state_d = S_RUN;
      end
      S_RUN: begin
        if (17'(rd_addr_q) == len_q - 17'd1) state_d = S_DRAIN;
        else                                 rd_addr_d = rd_addr_q + 1'b1;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        int_d   = 2'b01;
        state_d = S_IDLE;
      end
      S_ERR: begin
        int_d   = 2'b11;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) || (int_d != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q <= S_IDLE; len_q <= '0; mode_q <= '0; sh_q <= '0;
      rd_addr_q <= '0; idx_q <= '0; wr_addr_q <= '0; wr_data_q <= '0;
      wr_en_q <= 1'b0; int_q <= '0; err_q <= 1'b0; win_q <= '0;
      dvld_q <= 1'b0; busy_q <= 1'b0;
    end else if (en_s) begin
      state_q <= state_d; len_q <= len_d; mode_q <= mode_d; sh_q <= sh_d;
      rd_addr_q <= rd_addr_d; idx_q <= idx_d; wr_addr_q <= wr_addr_d; wr_data_q <= wr_data_d;
      wr_en_q <= wr_en_d; int_q <= int_d; err_q <= err_d; win_q <= win_d;
      dvld_q <= dvld_d; busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      frz_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      frz_q  <= frz_d;
      hold_q <= hold_d;
    end
  end

  assign rd_addr_MemIn0  = rd_addr_q;
  assign data_MemOut0    = wr_data_q;
  assign wr_addr_MemOut0 = wr_addr_q;
  assign wr_en_MemOut0   = wr_en_q & en_s;

  always_comb begin
    status_IPcore    = '0;
    status_IPcore[0] = busy_q;
    status_IPcore[1] = err_q;
    status_IPcore[2] = sat_flag;
    int_IPcore       = '0;
    int_IPcore[1:0]  = int_q & {2{en_s}};
  end
endmodule

// File: tb/tb_aip_conv1d_core.sv
// Directed self-checking bench for aip_conv1d_core: logs writes/pulses per cycle and checks
// them against hand-computed results and cycle offsets from the start cycle t.
module tb_aip_conv1d_core;
  logic        clk = 1'b0, rst_a, en_s, start;
  logic [31:0] din, cfg, dout;
  logic [5:0]  rd_addr, wr_addr;
  logic        wr_en;
  logic [7:0]  status, intr;

  aip_conv1d_core dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start_IPcore(start),
    .data_MemIn0(din), .rd_addr_MemIn0(rd_addr), .data_ConfigReg(cfg),
    .data_MemOut0(dout), .wr_addr_MemOut0(wr_addr), .wr_en_MemOut0(wr_en),
    .status_IPcore(status), .int_IPcore(intr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [64];
  always @(posedge clk) din <= mem[rd_addr];

  int          wa_q[$], wc_q[$], done_q[$], errp_q[$], busy_q[$];
  logic [31:0] wd_q[$];
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(int'(wr_addr)); wd_q.push_back(dout); wc_q.push_back(cyc);
    end
    if (intr[0])   done_q.push_back(cyc);
    if (intr[1])   errp_q.push_back(cyc);
    if (status[0]) busy_q.push_back(cyc);
  end

  int errors = 0, checks = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] mk(input int len, input int mode, input int sh);
    logic [31:0] c;
    c = '0; c[15:0] = 16'(len); c[17:16] = 2'(mode); c[22:18] = 5'(sh);
    return c;
  endfunction

  task automatic launch(input logic [31:0] c, output int t);
    start = 1'b1; cfg = c; t = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; en_s = 1'b1; start = 1'b0; cfg = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    tick(3);
    checks++;
    if ({rd_addr, wr_addr, wr_en, status, intr, dout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h wa=%h we=%b st=%h int=%h d=%h required all 0",
               rd_addr, wr_addr, wr_en, status, intr, dout);
    end
    rst_a = 1'b0;
    tick(2);
  endtask

  task automatic test_pass;
    logic [31:0] e [4];
    int t, wb, db, bb;
    e = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd1};
    for (int i = 0; i < 4; i++) mem[i] = e[i];
    wb = wa_q.size(); db = done_q.size(); bb = busy_q.size();
    launch(mk(4, 0, 0), t);
    tick(12);
    checks++;
    if (wa_q.size() - wb !== 4) begin
      errors++; $display("FAIL pass_nwrites: got %0d required 4", wa_q.size() - wb);
    end
    for (int i = 0; i < 4 && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[wb+i] !== i || wd_q[wb+i] !== e[i] || wc_q[wb+i] !== t + 3 + i) begin
        errors++;
        $display("FAIL pass_write[%0d]: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d",
                 i, wa_q[wb+i], wd_q[wb+i], wc_q[wb+i] - t, i, e[i], 3 + i);
      end
    end
    checks++;
    if (done_q.size() - db !== 1 || done_q[db] !== t + 7) begin
      errors++; $display("FAIL pass_done: got n=%0d required one pulse at t+7", done_q.size() - db);
    end
    checks++;
    if (busy_q.size() - bb !== 7 || busy_q[bb] !== t + 1 || busy_q[busy_q.size()-1] !== t + 7) begin
      errors++; $display("FAIL pass_busy: got %0d busy cycles required 7 (t+1..t+7)", busy_q.size() - bb);
    end
  endtask

  task automatic test_sum;
    logic [31:0] e [6];
    int t, wb;
    e = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd14, 32'd18};
    for (int i = 0; i < 6; i++) mem[i] = 32'(2 * (i + 1));
    wb = wa_q.size();
    launch(mk(6, 1, 1), t);
    tick(14);
    checks++;
    if (wa_q.size() - wb !== 6) begin
      errors++; $display("FAIL sum_nwrites: got %0d required 6", wa_q.size() - wb);
    end
    for (int i = 0; i < 6 && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[wb+i] !== i || wd_q[wb+i] !== e[i]) begin
        errors++;
        $display("FAIL sum_write[%0d]: got a=%0d d=%h required a=%0d d=%h", i, wa_q[wb+i], wd_q[wb+i], i, e[i]);
      end
    end
  endtask

  task automatic test_diff_err;
    logic [31:0] e [3];
    int t, wb, db, eb, bb;
    e = '{32'd10, 32'hFFFF_FFFA, 32'd0};
    mem[0] = 32'd10; mem[1] = 32'd4; mem[2] = 32'd4;
    wb = wa_q.size();
    launch(mk(3, 2, 0), t);
    tick(10);
    checks++;
    if (wa_q.size() - wb !== 3) begin
      errors++; $display("FAIL diff_nwrites: got %0d required 3", wa_q.size() - wb);
    end
    for (int i = 0; i < 3 && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wd_q[wb+i] !== e[i]) begin
        errors++; $display("FAIL diff_write[%0d]: got %h required %h", i, wd_q[wb+i], e[i]);
      end
    end
    // illegal mode
    wb = wa_q.size(); db = done_q.size(); eb = errp_q.size();
    launch(mk(5, 3, 0), t);
    tick(8);
    checks++;
    if (wa_q.size() !== wb || status[1] !== 1'b1) begin
      errors++; $display("FAIL err_state: got writes=%0d status1=%b required 0 and 1", wa_q.size() - wb, status[1]);
    end
    checks++;
    if (errp_q.size() - eb !== 1 || done_q.size() - db !== 1 ||
        errp_q[eb] !== t + 2 || done_q[db] !== t + 2) begin
      errors++; $display("FAIL err_pulses: got err=%0d done=%0d required one of each at t+2",
                         errp_q.size() - eb, done_q.size() - db);
    end
    // L=0 job: clears error, done at t+2, no writes
    wb = wa_q.size(); db = done_q.size(); bb = busy_q.size();
    launch(mk(0, 0, 0), t);
    tick(6);
    checks++;
    if (status[1] !== 1'b0 || wa_q.size() !== wb) begin
      errors++; $display("FAIL len0_state: got status1=%b writes=%0d required 0 and 0", status[1], wa_q.size() - wb);
    end
    checks++;
    if (done_q.size() - db !== 1 || done_q[db] !== t + 2 || busy_q.size() - bb !== 2) begin
      errors++; $display("FAIL len0_done: got done=%0d busy=%0d required 1 at t+2, busy 2",
                         done_q.size() - db, busy_q.size() - bb);
    end
  endtask

  task automatic test_clamp;
    int t, wb, db, bad;
    for (int i = 0; i < 64; i++) mem[i] = 32'(3 * i + 1);
    wb = wa_q.size(); db = done_q.size(); bad = 0;
    launch(mk(100, 0, 0), t);
    tick(80);
    checks++;
    if (wa_q.size() - wb !== 64) begin
      errors++; $display("FAIL clamp_nwrites: got %0d required 64", wa_q.size() - wb);
    end
    for (int i = 0; i < 64 && wb + i < wa_q.size(); i++)
      if (wa_q[wb+i] !== i || wd_q[wb+i] !== 32'(3 * i + 1)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL clamp_data: got %0d bad writes required 0", bad);
    end
    checks++;
    if (done_q.size() - db !== 1 || done_q[db] !== t + 67) begin
      errors++; $display("FAIL clamp_done: got n=%0d required one pulse at t+67", done_q.size() - db);
    end
  endtask

  task automatic test_enable;
    int t, wb, db;
    int ec [4];
    ec = '{3, 7, 8, 9};
    for (int i = 0; i < 4; i++) mem[i] = 32'(20 + i);
    wb = wa_q.size(); db = done_q.size();
    launch(mk(4, 0, 0), t);
    tick(3);
    en_s = 1'b0;
    tick(3);
    en_s = 1'b1;
    tick(10);
    checks++;
    if (wa_q.size() - wb !== 4) begin
      errors++; $display("FAIL en_nwrites: got %0d required 4", wa_q.size() - wb);
    end
    for (int i = 0; i < 4 && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[wb+i] !== i || wd_q[wb+i] !== 32'(20 + i) || wc_q[wb+i] !== t + ec[i]) begin
        errors++; $display("FAIL en_write[%0d]: got a=%0d d=%h c=t+%0d required a=%0d d=%h c=t+%0d",
                           i, wa_q[wb+i], wd_q[wb+i], wc_q[wb+i] - t, i, 32'(20 + i), ec[i]);
      end
    end
    checks++;
    if (done_q.size() - db !== 1 || done_q[db] !== t + 10) begin
      errors++; $display("FAIL en_done: got n=%0d required one pulse at t+10", done_q.size() - db);
    end
  endtask

  task automatic test_restart_ignored;
    int t, wb, db, eb;
    for (int i = 0; i < 4; i++) mem[i] = 32'(9 - i);
    wb = wa_q.size(); db = done_q.size(); eb = errp_q.size();
    launch(mk(4, 0, 0), t);
    tick(3);
    start = 1'b1; cfg = mk(2, 3, 0);
    tick(1);
    start = 1'b0;
    tick(10);
    checks++;
    if (wa_q.size() - wb !== 4 || done_q.size() - db !== 1 || done_q[db] !== t + 7 ||
        errp_q.size() !== eb || status[1] !== 1'b0) begin
      errors++; $display("FAIL restart: got writes=%0d done=%0d errp=%0d required 4, 1 at t+7, 0",
                         wa_q.size() - wb, done_q.size() - db, errp_q.size() - eb);
    end
    for (int i = 0; i < 4 && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wd_q[wb+i] !== 32'(9 - i)) begin
        errors++; $display("FAIL restart_write[%0d]: got %h required %h", i, wd_q[wb+i], 32'(9 - i));
      end
    end
  endtask

  task automatic test_reset_mid;
    int t, wb, db;
    for (int i = 0; i < 8; i++) mem[i] = 32'(100 + i);
    wb = wa_q.size(); db = done_q.size();
    launch(mk(8, 0, 0), t);
    tick(3);
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    tick(12);
    checks++;
    if (wa_q.size() - wb !== 2 || done_q.size() !== db) begin
      errors++; $display("FAIL rst_mid: got writes=%0d done=%0d required 2 and 0",
                         wa_q.size() - wb, done_q.size() - db);
    end
    checks++;
    if (status !== 8'h00 || wr_en !== 1'b0 || intr !== 8'h00) begin
      errors++; $display("FAIL rst_mid_status: got status=%h we=%b int=%h required 0", status, wr_en, intr);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] e [4];
    int t, wb;
`ifdef AIP_CONV1D_SAT_EN
    e = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
`else
    e = '{32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFD, 32'hFFFF_FFFC};
`endif
    for (int i = 0; i < 4; i++) mem[i] = 32'h7FFF_FFFF;
    wb = wa_q.size();
    launch(mk(4, 1, 0), t);
    tick(12);
    checks++;
    if (wa_q.size() - wb !== 4) begin
      errors++; $display("FAIL ovf_nwrites: got %0d required 4", wa_q.size() - wb);
    end
    for (int i = 0; i < 4 && wb + i < wa_q.size(); i++) begin
      checks++;
      if (wd_q[wb+i] !== e[i]) begin
        errors++; $display("FAIL ovf_write[%0d]: got %h required %h", i, wd_q[wb+i], e[i]);
      end
    end
    checks++;
`ifdef AIP_CONV1D_SAT_EN
    if (status[2] !== 1'b1) begin
      errors++; $display("FAIL ovf_sat_flag: got %b required 1", status[2]);
    end
`else
    if (status[2] !== 1'b0) begin
      errors++; $display("FAIL ovf_sat_flag: got %b required 0", status[2]);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_pass;
    test_sum;
    test_diff_err;
    test_clamp;
    test_enable;
    test_restart_ignored;
    test_reset_mid;
    test_overflow;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
